// File: rtl/uart_io_button_ctrl_pkg.sv
// Shared constants and types for the debounced push-button controller.
package uart_io_button_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int unsigned EDGE_FALL = 0;
  localparam int unsigned EDGE_RISE = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/uart_io_button_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line between the CPU side and the button controller.
interface uart_io_button_ctrl_if;

  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, read, write, writedata, input readdata, irq);
  modport slave  (input address, read, write, writedata, output readdata, irq);

endinterface

// File: rtl/uart_io_button_ctrl_debounce.sv
// One button bit: 2-FF synchroniser followed by a counting debouncer.
module uart_io_button_debounce
  import uart_io_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_deb
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Accept on the mismatch cycle that would bring the count to DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  deb_state_e       r_state;

  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_deb_nxt;
  logic             w_diff;

  assign w_diff = r_sync ^ r_deb;
  assign o_sync = r_sync;
  assign o_deb  = r_deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_deb   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_deb   <= w_deb_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STABLE:   if (w_diff) w_state_nxt = COUNTING;
      COUNTING: if (!w_diff || (r_cnt == CNT_LAST)) w_state_nxt = STABLE;
      default:  w_state_nxt = STABLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = '0;
    w_deb_nxt = r_deb;
    case (r_state)
      STABLE: begin
        if (w_diff) w_cnt_nxt = CNT_W'(1);
      end
      COUNTING: begin
        if (w_diff) begin
          if (r_cnt == CNT_LAST) begin
            w_deb_nxt = r_sync;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

endmodule

// File: rtl/uart_io_button_ctrl.sv
// Debounced push-button controller: edge capture (W1C), interrupt mask and Avalon-MM register slave.
module uart_io_button_ctrl
  import uart_io_button_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  uart_io_button_ctrl_if.slave bus
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_mask;
  logic [31:0]      w_rdata;
  logic             w_unused;

  logic [WIDTH-1:0] r_deb_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [31:0]      r_readdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    uart_io_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (in_port[g]),
      .o_sync (w_sync[g]),
      .o_deb  (w_deb[g])
    );
  end

  always_comb begin
    w_edge = '0;
    if (EDGE_TYPE == EDGE_FALL)      w_edge = r_deb_d & ~w_deb;
    else if (EDGE_TYPE == EDGE_RISE) w_edge = ~r_deb_d & w_deb;
    else                             w_edge = r_deb_d ^ w_deb;
  end

  assign w_wr_mask = bus.write && (bus.address == ADDR_MASK);
  assign w_clr     = (bus.write && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused  = ^bus.writedata;

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA: w_rdata = 32'(w_deb);
      ADDR_MASK: w_rdata = 32'(r_mask);
      ADDR_EDGE: w_rdata = 32'(r_cap);
      ADDR_RAW:  w_rdata = 32'(w_sync);
      default:   w_rdata = '0;
    endcase
  end

  // A new edge beats a same-cycle W1C clear of that bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb_d    <= '1;
      r_mask     <= '0;
      r_cap      <= '0;
      r_readdata <= '0;
    end else begin
      r_deb_d <= w_deb;
      r_cap   <= (r_cap & ~w_clr) | w_edge;
      if (w_wr_mask) r_mask <= bus.writedata[WIDTH-1:0];
      if (bus.read)  r_readdata <= w_rdata;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_uart_io_button_ctrl.sv
// Self-checking bench for uart_io_button_ctrl with DEBOUNCE_CYCLES=4, WIDTH=2, falling-edge capture.
module tb_uart_io_button_ctrl;
  import uart_io_button_pkg::*;

  typedef struct {
    int          edge_no;
    logic [1:0]  addr;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in_port;
  logic       rd_seen = 1'b0;
  int         n_checks = 0;
  int         n_err = 0;
  sb_t        exp_q[$];

  uart_io_button_ctrl_if bus();

  uart_io_button_ctrl #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reads are scored one cycle after the edge that sampled them.
  always @(posedge clk) rd_seen <= bus.read;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL scoreboard: readdata 0x%0h with nothing expected", bus.readdata);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        check(e.name, bus.readdata, e.exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
    sb_t e;
    bus.address = addr;
    bus.read    = 1'b1;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
    drive_read(addr, exp, name);
    tick();
    bus.read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address   = addr;
    bus.writedata = data;
    bus.write     = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  // Step happens before edge 1; rows say which edge samples each read.
  task automatic run_step(input logic [1:0] level, input rd_vec_t rows[$], input int n_edges,
                          input int wr_edge);
    in_port = level;
    for (int k = 1; k <= n_edges; k++) begin
      bus.read  = 1'b0;
      bus.write = 1'b0;
      foreach (rows[r]) begin
        if (rows[r].edge_no == k) drive_read(rows[r].addr, rows[r].exp, rows[r].name);
      end
      if (k == wr_edge) begin
        bus.address   = ADDR_EDGE;
        bus.writedata = 32'h1;
        bus.write     = 1'b1;
      end
      tick();
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t reset_vecs[$];
    rd_vec_t press_vecs[$];
    rd_vec_t none_vecs[$];
    rd_vec_t pre_rst_vecs[$];

    reset_vecs = '{
      '{0, ADDR_DATA, 32'h3, "rst_data"},
      '{0, ADDR_MASK, 32'h0, "rst_mask"},
      '{0, ADDR_EDGE, 32'h0, "rst_edge"},
      '{0, ADDR_RAW,  32'h3, "rst_raw"}
    };
    press_vecs = '{
      '{5, ADDR_DATA, 32'h3, "data_before_accept"},
      '{6, ADDR_EDGE, 32'h0, "edge_before_set"},
      '{7, ADDR_DATA, 32'h2, "data_after_accept"},
      '{8, ADDR_EDGE, 32'h1, "edge_after_set"}
    };
    pre_rst_vecs = '{
      '{1, ADDR_DATA, 32'h3, "data_pre_reset"}
    };

    reset         = 1'b1;
    in_port       = 2'b11;
    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    tick(3);
    reset = 1'b0;
    tick();

    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    foreach (reset_vecs[i]) do_read(reset_vecs[i].addr, reset_vecs[i].exp, reset_vecs[i].name);

    // Press bit 0 and follow the latency edge by edge.
    run_step(2'b10, press_vecs, 8, 0);
    tick(2);
    check("irq_masked_off", 32'(bus.irq), 32'h0);

    do_write(ADDR_MASK, 32'h1);
    check("irq_after_mask", 32'(bus.irq), 32'h1);
    do_read(ADDR_MASK, 32'h1, "mask_readback");
    do_write(ADDR_EDGE, 32'h1);
    check("irq_after_clear", 32'(bus.irq), 32'h0);
    do_read(ADDR_EDGE, 32'h0, "edge_after_clear");

    // Release is a rising edge and must not capture.
    in_port = 2'b11;
    tick(12);
    do_read(ADDR_DATA, 32'h3, "data_released");
    do_read(ADDR_EDGE, 32'h0, "no_rise_capture");

    // Three-cycle glitch on bit 1 is rejected.
    in_port = 2'b01;
    tick(3);
    in_port = 2'b11;
    tick(12);
    do_read(ADDR_DATA, 32'h3, "glitch_data");
    do_read(ADDR_EDGE, 32'h0, "glitch_edge");
    check("glitch_irq", 32'(bus.irq), 32'h0);

    // Clear lands on the same edge the capture sets: set wins.
    run_step(2'b10, none_vecs, 7, 7);
    check("set_wins_irq", 32'(bus.irq), 32'h1);
    do_read(ADDR_EDGE, 32'h1, "set_wins_edge");
    do_write(ADDR_EDGE, 32'h1);
    do_read(ADDR_EDGE, 32'h0, "edge_cleared_again");
    in_port = 2'b11;
    tick(12);

    // Reset with the counter at 2, button released while in reset.
    run_step(2'b10, pre_rst_vecs, 4, 0);
    reset   = 1'b1;
    in_port = 2'b11;
    #1;
    check("async_rst_readdata", bus.readdata, 32'h0);
    check("async_rst_irq", 32'(bus.irq), 32'h0);
    tick();
    reset = 1'b0;
    tick(12);
    foreach (reset_vecs[i]) do_read(reset_vecs[i].addr, reset_vecs[i].exp, {"post_", reset_vecs[i].name});
    check("post_rst_irq", 32'(bus.irq), 32'h0);

    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
